// File: rtl/bram_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_access_ctrl_pkg
// Description : Shared helpers for the block-RAM access controller: address
//               width calculation, legal RAM read latencies and the response
//               FIFO depth derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_access_ctrl_pkg;

  // RAM built without / with its optional output register.
  localparam int READ_LATENCY_NO_OREG = 1;
  localparam int READ_LATENCY_OREG    = 2;

  // Number of bits needed to hold the value 'depth' (0 for depth 0).
  function automatic int clogb2(input int depth);
    int d;
    int r;
    d = depth;
    for (r = 0; d > 0; r++) begin
      d = d >> 1;
    end
    return r;
  endfunction

  function automatic bit is_legal_latency(input int lat);
    return (lat == READ_LATENCY_NO_OREG) || (lat == READ_LATENCY_OREG);
  endfunction

  // One slot per in-flight read plus two slack entries keeps the request
  // channel streaming at full rate while the consumer accepts every cycle.
  function automatic int fifo_depth(input int lat);
    return lat + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bram_rsp_fifo
// Description : Small synchronous FIFO holding RAM read responses. Push has
//               no full check (the caller guarantees space by credit); pop
//               on an empty FIFO is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rsp_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  // Pointer increment with wrap for non-power-of-two depths.
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop   = i_pop && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      if (i_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!i_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_access_ctrl
// Description : Requester-side controller for a single-port read-first block
//               RAM. Accepts valid/ready requests, drives the RAM port, tracks
//               the fixed read latency and returns one in-order response per
//               request through a credit-protected response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_access_ctrl
  import bram_access_ctrl_pkg::*;
#(
  parameter  int RAM_WIDTH    = 32,
  parameter  int RAM_DEPTH    = 1024,
  parameter  int READ_LATENCY = 2,
  localparam int AW           = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AW-1:0]        req_addr,
  input  logic [RAM_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RAM_WIDTH-1:0] rsp_rdata,
  output logic [AW-1:0]        bram_addra,
  output logic [RAM_WIDTH-1:0] bram_dina,
  output logic                 bram_wea,
  output logic                 bram_ena,
  output logic                 bram_regcea,
  output logic                 bram_rsta,
  input  logic [RAM_WIDTH-1:0] bram_douta
);

  localparam int            FIFO_DEPTH = fifo_depth(READ_LATENCY);
  localparam int            CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   CRED_LIMIT = (CW + 1)'(FIFO_DEPTH);

  if (!is_legal_latency(READ_LATENCY)) begin : g_bad_latency
    $error("bram_access_ctrl: READ_LATENCY must be 1 or 2");
  end

  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic [CW-1:0]           w_inflight;
  logic [CW-1:0]           w_fifo_count;
  logic [CW:0]             w_credit_used;

  // Every in-flight read and every queued response holds one FIFO credit,
  // so ready is purely a function of registered state.
  assign w_credit_used = {1'b0, w_inflight} + {1'b0, w_fifo_count};
  assign req_ready     = (w_credit_used < CRED_LIMIT);
  assign w_accept      = req_valid && req_ready;

  // RAM port is driven straight from the request so the RAM samples it
  // at the end of the accept cycle.
  assign bram_ena   = w_accept;
  assign bram_wea   = w_accept && req_we;
  assign bram_addra = req_addr;
  assign bram_dina  = req_wdata;
  assign bram_rsta  = ~rsta_n;

  if (READ_LATENCY == READ_LATENCY_OREG) begin : g_regce_oreg
    // Load the RAM output register only when stage 1 holds a live read.
    assign bram_regcea = r_pipe_vld[0];
  end else begin : g_regce_none
    assign bram_regcea = 1'b1;
  end

  // Latency tracker: one valid bit per RAM pipeline stage, advancing freely.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld <= (r_pipe_vld << 1) | READ_LATENCY'(w_accept);
    end
  end

  // Count reads still travelling through the RAM.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_pipe_vld[i]);
    end
  end

  assign w_push = r_pipe_vld[READ_LATENCY-1];
  assign w_pop  = rsp_valid && rsp_ready;

  bram_rsp_fifo #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clka),
    .rst_n       (rsta_n),
    .i_push      (w_push),
    .i_push_data (bram_douta),
    .i_pop       (w_pop),
    .o_valid     (rsp_valid),
    .o_data      (rsp_rdata),
    .o_count     (w_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_bram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_access_ctrl
// Description : Self-checking bench for bram_access_ctrl with a behavioural
//               read-first RAM and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_access_ctrl;

  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int FD    = LAT + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rsta_n;
  // READ_LATENCY=2 instance
  logic          req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr, bram_addra;
  logic [W-1:0]  req_wdata, rsp_rdata, bram_dina, bram_douta;
  logic          bram_wea, bram_ena, bram_regcea, bram_rsta;
  // READ_LATENCY=1 instance
  logic          req_valid_1, req_ready_1, req_we_1, rsp_valid_1, rsp_ready_1;
  logic [AW-1:0] req_addr_1, bram_addra_1;
  logic [W-1:0]  req_wdata_1, rsp_rdata_1, bram_dina_1, bram_douta_1;
  logic          bram_wea_1, bram_ena_1, bram_regcea_1, bram_rsta_1;

  bram_access_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(2)) dut (
    .clka(clk), .rsta_n(rsta_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
    .bram_ena(bram_ena), .bram_regcea(bram_regcea), .bram_rsta(bram_rsta),
    .bram_douta(bram_douta));

  bram_access_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(1)) dut_l1 (
    .clka(clk), .rsta_n(rsta_n),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_we(req_we_1),
    .req_addr(req_addr_1), .req_wdata(req_wdata_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_rdata(rsp_rdata_1),
    .bram_addra(bram_addra_1), .bram_dina(bram_dina_1), .bram_wea(bram_wea_1),
    .bram_ena(bram_ena_1), .bram_regcea(bram_regcea_1), .bram_rsta(bram_rsta_1),
    .bram_douta(bram_douta_1));

  // Read-first RAM with output register (latency 2).
  logic [W-1:0] ram0 [DEPTH] = '{default: '0};
  logic [W-1:0] ram0_q;
  always @(posedge clk) begin
    if (bram_ena) begin
      ram0_q <= ram0[bram_addra];
      if (bram_wea) ram0[bram_addra] <= bram_dina;
    end
    if (bram_rsta)        bram_douta <= '0;
    else if (bram_regcea) bram_douta <= ram0_q;
  end

  // Read-first RAM without output register (latency 1).
  logic [W-1:0] ram1 [DEPTH] = '{default: '0};
  always @(posedge clk) begin
    if (bram_rsta_1) bram_douta_1 <= '0;
    else if (bram_ena_1) begin
      bram_douta_1 <= ram1[bram_addra_1];
      if (bram_wea_1) ram1[bram_addra_1] <= bram_dina_1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stalls   = 0;
  bit rr_rand  = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Random consumer backpressure.
  always begin
    @(posedge clk);
    #1;
    if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
  end

  // Reference model: memory image plus queue of expected responses, each
  // becoming visible LAT+1 cycles after its accept.
  typedef struct {
    logic [W-1:0] data;
    int           t;
  } exp_t;
  exp_t         q[$];
  logic [W-1:0] ref_mem [DEPTH] = '{default: '0};
  bit           prev_acc = 1'b0;
  logic [W-1:0] pop_log[$];
  int           pop_cyc[$];
  int           acc_cyc[$];

  always @(negedge clk) begin : compare
    bit   exp_rv;
    bit   acc;
    exp_t e;
    if (!rsta_n) begin
      q.delete();
      prev_acc = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_bram_ena", 32'(bram_ena), 32'd0);
      chk("rst_bram_wea", 32'(bram_wea), 32'd0);
      chk("rst_bram_regcea", 32'(bram_regcea), 32'd0);
      chk("rst_bram_rsta", 32'(bram_rsta), 32'd1);
    end else begin
      exp_rv = (q.size() > 0) && (q[0].t <= cyc);
      acc    = req_valid && (q.size() < FD);
      chk("req_ready", 32'(req_ready), 32'(q.size() < FD));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("bram_rsta", 32'(bram_rsta), 32'd0);
      chk("bram_regcea", 32'(bram_regcea), 32'(prev_acc));
      chk("bram_ena", 32'(bram_ena), 32'(acc));
      chk("bram_wea", 32'(bram_wea), 32'(acc && req_we));
      if (acc) begin
        chk("bram_addra", 32'(bram_addra), 32'(req_addr));
        chk("bram_dina", bram_dina, req_wdata);
      end
      if (exp_rv && rsp_ready) begin
        chk("rsp_rdata", rsp_rdata, q[0].data);
        pop_log.push_back(rsp_rdata);
        pop_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (acc) begin
        e.data = ref_mem[req_addr];
        e.t    = cyc + LAT + 1;
        q.push_back(e);
        if (req_we) ref_mem[req_addr] = req_wdata;
        acc_cyc.push_back(cyc);
      end
      prev_acc = acc;
    end
  end

  // Latency-1 instance observer.
  logic [W-1:0] l1_data[$];
  int           l1_cyc[$];
  always @(negedge clk) begin
    if (rsta_n) begin
      chk("l1_regcea", 32'(bram_regcea_1), 32'd1);
      if (rsp_valid_1) begin
        l1_data.push_back(rsp_rdata_1);
        l1_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    pop_log.delete();
    pop_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic send(input bit we, input int addr, input logic [W-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = AW'(addr);
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int nacc;
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    req_valid_1 = 0; req_we_1 = 0; req_addr_1 = '0; req_wdata_1 = '0;
    rsp_ready = 1'b1; rsp_ready_1 = 1'b1;
    rsta_n = 1'b0;
    tick(3);
    rsta_n = 1'b1;
    tick(2);

    // Write then read the same address.
    clear_logs();
    send(1'b1, 5, 32'hDEADBEEF);
    send(1'b0, 5, '0);
    drain();
    chk("wr_rd_count", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2 && acc_cyc.size() == 2) begin
      chk("wr_rsp_old", pop_log[0], 32'h0);
      chk("rd_rsp_new", pop_log[1], 32'hDEADBEEF);
      chk("rd_latency", 32'(pop_cyc[1] - acc_cyc[1]), 32'd3);
    end

    // Prefill 0..15 with addr*3, then stream reads.
    for (int i = 0; i < 16; i++) send(1'b1, i, 32'(i * 3));
    drain();
    clear_logs();
    stalls = 0;
    for (int i = 0; i < 16; i++) send(1'b0, i, '0);
    drain();
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_count", 32'(pop_log.size()), 32'd16);
    if (pop_log.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("stream_data", pop_log[i], 32'(i * 3));
      chk("stream_back_to_back", 32'(pop_cyc[15] - pop_cyc[0]), 32'd15);
    end

    // Backpressure: only FIFO_DEPTH accepts while the consumer stalls.
    clear_logs();
    rsp_ready = 1'b0;
    nacc = 0;
    req_valid = 1'b1;
    req_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_addr = AW'(nacc);
      @(negedge clk);
      if (req_ready) nacc++;
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", 32'(nacc), 32'd4);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int k = nacc; k < 10; k++) send(1'b0, k, '0);
    drain();
    chk("bp_count", 32'(pop_log.size()), 32'd10);
    if (pop_log.size() == 10 && acc_cyc.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("bp_data", pop_log[i], 32'(i * 3));
      chk("bp_resume", 32'(acc_cyc[4] - pop_cyc[0]), 32'd1);
    end

    // Random traffic against the reference model.
    clear_logs();
    rr_rand = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom());
      if ($urandom_range(0, 7) == 0) tick(1);
    end
    rr_rand = 1'b0;
    tick(1);
    rsp_ready = 1'b1;
    drain();
    chk("rand_count", 32'(pop_log.size()), 32'd2000);

    // Reset with reads in flight.
    send(1'b1, 7, 32'h12345678);
    drain();
    clear_logs();
    rsp_ready = 1'b0;
    send(1'b0, 1, '0);
    send(1'b0, 2, '0);
    send(1'b0, 3, '0);
    rsta_n = 1'b0;
    #1;
    chk("rst_now_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_now_req_ready", 32'(req_ready), 32'd1);
    tick(2);
    rsta_n = 1'b1;
    rsp_ready = 1'b1;
    tick(10);
    chk("no_rsp_after_rst", 32'(pop_log.size()), 32'd0);
    send(1'b0, 7, '0);
    drain();
    chk("post_rst_count", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() == 1) chk("post_rst_data", pop_log[0], 32'h12345678);

    // Latency-1 instance: write then read back to back.
    begin
      int t0, t1;
      req_valid_1 = 1'b1; req_we_1 = 1'b1; req_addr_1 = AW'(3); req_wdata_1 = 32'hA5A5A5A5;
      @(negedge clk);
      t0 = cyc;
      chk("l1_ready0", 32'(req_ready_1), 32'd1);
      @(posedge clk); #1;
      req_we_1 = 1'b0;
      @(negedge clk);
      t1 = cyc;
      chk("l1_ready1", 32'(req_ready_1), 32'd1);
      @(posedge clk); #1;
      req_valid_1 = 1'b0;
      tick(6);
      chk("l1_count", 32'(l1_data.size()), 32'd2);
      if (l1_data.size() == 2) begin
        chk("l1_wr_time", 32'(l1_cyc[0] - t0), 32'd2);
        chk("l1_rd_time", 32'(l1_cyc[1] - t1), 32'd2);
        chk("l1_wr_data", l1_data[0], 32'h0);
        chk("l1_rd_data", l1_data[1], 32'hA5A5A5A5);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
